mdio_cmd_arbiter: RTL and testbench

//  Shares one mdio_interface master among NUM_REQ requesters (PHY init FSM, link poller, CPU bridge).

---
 rtl/mdio_cmd_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mdio_cmd_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_cmd_arbiter.sv
// mdio_cmd_arbiter: shares one MDIO master between NUM_REQ requesters using
// round-robin arbitration. The winner's command is latched, the master's begin
// strobe is pulsed and the arbiter waits for finish. Read data and a done/err
// strobe go back to the owning requester only.
// Optional feature macro: MDIO_TIMEOUT_EN. When it is defined, a 32-bit watchdog
// ends a command that runs TIMEOUT_CYC cycles without finish (err=1,
// rdata=16'hFFFF). Without it, WAIT waits indefinitely.
module mdio_cmd_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic                    sys_clk_100m,
  input  logic                    sys_rst_n,
  input  logic [NUM_REQ-1:0]      i_req,
  input  logic [2*NUM_REQ-1:0]    i_req_op,
  input  logic [5*NUM_REQ-1:0]    i_req_phy_addr,
  input  logic [5*NUM_REQ-1:0]    i_req_reg_addr,
  input  logic [16*NUM_REQ-1:0]   i_req_wdata,
  output logic [NUM_REQ-1:0]      o_req_ack,
  output logic [NUM_REQ-1:0]      o_req_done,
  output logic                    o_req_err,
  output logic [15:0]             o_req_rdata,
  output logic [1:0]              o_operation,
  output logic [4:0]              o_phy_addr,
  output logic [4:0]              o_reg_addr,
  output logic [15:0]             o_write_data,
  output logic                    o_operation_begin,
  input  logic [15:0]             i_master_read_data,
  input  logic                    i_master_read_valid,
  input  logic                    i_operation_finish,
  input  logic                    i_mdio_master_busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state;
  state_t        next_state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] win;
  logic [IW-1:0] pick;
  logic          pick_valid;
  logic          first_wait;
  logic          err_flag;
  logic          op_ok;
  logic          finish_seen;
  logic          timeout_hit;

  // Only write (01) and read (10) are real MDIO operations.
  assign op_ok       = (o_operation == 2'b01) || (o_operation == 2'b10);
  // Finish is not trusted in the first WAIT cycle (master may still show the previous one).
  assign finish_seen = i_operation_finish && !first_wait;

  // Round-robin pick: first requester at or after ptr, wrapping at NUM_REQ.
  always_comb begin
    int idx;
    idx        = 0;
    pick       = '0;
    pick_valid = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (i_req[idx]) begin
        pick       = IW'(idx);
        pick_valid = 1'b1;
      end
    end
  end

`ifdef MDIO_TIMEOUT_EN
  logic [31:0] timer;

  // Watchdog: cleared while issuing, counts every WAIT cycle.
  always_ff @(posedge sys_clk_100m) begin
    if (!sys_rst_n)          timer <= '0;
    else if (state == ISSUE) timer <= '0;
    else if (state == WAIT)  timer <= timer + 32'd1;
  end

  // A genuine finish in the same cycle as expiry takes priority over the timeout.
  assign timeout_hit = (state == WAIT) && !finish_seen &&
                       (timer == 32'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge sys_clk_100m) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pick_valid && !i_mdio_master_busy) next_state = ISSUE;
      ISSUE:   next_state = op_ok ? WAIT : DONE;
      WAIT:    if (finish_seen || timeout_hit) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Command latch, registered strobes, read-data capture and rr pointer update.
  always_ff @(posedge sys_clk_100m) begin
    if (!sys_rst_n) begin
      ptr               <= '0;
      win               <= '0;
      first_wait        <= 1'b0;
      err_flag          <= 1'b0;
      o_req_ack         <= '0;
      o_req_done        <= '0;
      o_req_err         <= 1'b0;
      o_req_rdata       <= 16'h0000;
      o_operation       <= 2'b00;
      o_phy_addr        <= 5'h00;
      o_reg_addr        <= 5'h00;
      o_write_data      <= 16'h0000;
      o_operation_begin <= 1'b0;
    end else begin
      o_req_ack         <= '0;
      o_req_done        <= '0;
      o_req_err         <= 1'b0;
      o_operation_begin <= 1'b0;
      case (state)
        IDLE: begin
          if (next_state == ISSUE) begin
            win          <= pick;
            err_flag     <= 1'b0;
            o_operation  <= i_req_op[int'(pick)*2 +: 2];
            o_phy_addr   <= i_req_phy_addr[int'(pick)*5 +: 5];
            o_reg_addr   <= i_req_reg_addr[int'(pick)*5 +: 5];
            o_write_data <= i_req_wdata[int'(pick)*16 +: 16];
          end
        end
        ISSUE: begin
          o_req_ack         <= NUM_REQ'(1) << win;
          o_operation_begin <= op_ok;
          first_wait        <= 1'b1;
          if (!op_ok) err_flag <= 1'b1;
        end
        WAIT: begin
          first_wait <= 1'b0;
          if ((o_operation == 2'b10) && i_master_read_valid)
            o_req_rdata <= i_master_read_data;
          if (timeout_hit) begin
            err_flag    <= 1'b1;
            o_req_rdata <= 16'hFFFF;
          end
        end
        DONE: begin
          o_req_done <= NUM_REQ'(1) << win;
          o_req_err  <= err_flag;
          ptr        <= (int'(win) == NUM_REQ - 1) ? '0 : win + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_cmd_arbiter.sv
// Directed testbench for mdio_cmd_arbiter (NUM_REQ=2, TIMEOUT_CYC=100).
// Inputs are driven 1 ns after the rising edge and outputs are sampled there too.
module tb_mdio_cmd_arbiter;

  logic        sys_clk_100m = 1'b0;
  logic        sys_rst_n;
  logic [1:0]  i_req;
  logic [3:0]  i_req_op;
  logic [9:0]  i_req_phy_addr;
  logic [9:0]  i_req_reg_addr;
  logic [31:0] i_req_wdata;
  logic [1:0]  o_req_ack;
  logic [1:0]  o_req_done;
  logic        o_req_err;
  logic [15:0] o_req_rdata;
  logic [1:0]  o_operation;
  logic [4:0]  o_phy_addr;
  logic [4:0]  o_reg_addr;
  logic [15:0] o_write_data;
  logic        o_operation_begin;
  logic [15:0] i_master_read_data;
  logic        i_master_read_valid;
  logic        i_operation_finish;
  logic        i_mdio_master_busy;

  int tests = 0;
  int fails = 0;

  mdio_cmd_arbiter #(.NUM_REQ(2), .TIMEOUT_CYC(100)) dut (
    .sys_clk_100m        (sys_clk_100m),
    .sys_rst_n           (sys_rst_n),
    .i_req               (i_req),
    .i_req_op            (i_req_op),
    .i_req_phy_addr      (i_req_phy_addr),
    .i_req_reg_addr      (i_req_reg_addr),
    .i_req_wdata         (i_req_wdata),
    .o_req_ack           (o_req_ack),
    .o_req_done          (o_req_done),
    .o_req_err           (o_req_err),
    .o_req_rdata         (o_req_rdata),
    .o_operation         (o_operation),
    .o_phy_addr          (o_phy_addr),
    .o_reg_addr          (o_reg_addr),
    .o_write_data        (o_write_data),
    .o_operation_begin   (o_operation_begin),
    .i_master_read_data  (i_master_read_data),
    .i_master_read_valid (i_master_read_valid),
    .i_operation_finish  (i_operation_finish),
    .i_mdio_master_busy  (i_mdio_master_busy)
  );

  always #5 sys_clk_100m = ~sys_clk_100m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk_100m);
    #1;
  endtask

  // From the first WAIT cycle: finish in the second WAIT cycle, return the done strobe.
  task automatic complete(output logic [1:0] done_seen, output logic err_seen);
    tick();
    i_operation_finish = 1'b1;
    tick();
    i_operation_finish = 1'b0;
    tick();
    done_seen = o_req_done;
    err_seen  = o_req_err;
  endtask

  logic [1:0] d;
  logic       e;
  logic [1:0] rr_exp [4];
  int         n;
  bit         got_done;

  initial begin
    rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
    sys_rst_n           = 1'b0;
    i_req               = '0;
    i_req_op            = '0;
    i_req_phy_addr      = '0;
    i_req_reg_addr      = '0;
    i_req_wdata         = '0;
    i_master_read_data  = '0;
    i_master_read_valid = 1'b0;
    i_operation_finish  = 1'b0;
    i_mdio_master_busy  = 1'b0;
    repeat (3) tick();
    check("rst_ack", 32'(o_req_ack), 32'h0);
    check("rst_done", 32'(o_req_done), 32'h0);
    check("rst_begin", 32'(o_operation_begin), 32'h0);
    check("rst_rdata", 32'(o_req_rdata), 32'h0);
    check("rst_op", 32'(o_operation), 32'h0);
    sys_rst_n = 1'b1;
    tick();

    // 1: single write from requester 0
    i_req_op       = 4'b0001;
    i_req_phy_addr = {5'h00, 5'h0D};
    i_req_reg_addr = {5'h00, 5'h0C};
    i_req_wdata    = {16'h0000, 16'hAAAA};
    i_req          = 2'b01;
    tick();
    check("wr_ack_early", 32'(o_req_ack), 32'h0);
    tick();
    check("wr_ack", 32'(o_req_ack), 32'h1);
    check("wr_begin", 32'(o_operation_begin), 32'h1);
    check("wr_fields", {9'h0, o_operation, o_phy_addr, o_reg_addr, o_write_data},
          {9'h0, 2'b01, 5'h0D, 5'h0C, 16'hAAAA});
    i_req = 2'b00;
    complete(d, e);
    check("wr_done", 32'(d), 32'h1);
    check("wr_err", 32'(e), 32'h0);
    check("wr_op_stable", 32'(o_operation), 32'h1);

    // 2: single read from requester 1; finish in first WAIT cycle must be ignored
    i_req_op       = 4'b1000;
    i_req_phy_addr = {5'h03, 5'h00};
    i_req_reg_addr = {5'h01, 5'h00};
    i_req          = 2'b10;
    tick();
    tick();
    check("rd_ack", 32'(o_req_ack), 32'h2);
    i_req = 2'b00;
    i_operation_finish = 1'b1;
    tick();
    i_operation_finish = 1'b0;
    tick();
    check("rd_early_finish_ignored", 32'(o_req_done), 32'h0);
    i_operation_finish  = 1'b1;
    i_master_read_valid = 1'b1;
    i_master_read_data  = 16'h1234;
    tick();
    i_operation_finish  = 1'b0;
    i_master_read_valid = 1'b0;
    i_master_read_data  = 16'h0000;
    tick();
    check("rd_done", 32'(o_req_done), 32'h2);
    check("rd_err", 32'(o_req_err), 32'h0);
    check("rd_rdata", 32'(o_req_rdata), 32'h1234);

    // 3: contention, both held: 0,1,0,1
    i_req_op = 4'b0101;
    i_req    = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick();
      tick();
      check($sformatf("rr_ack%0d", i), 32'(o_req_ack), 32'(rr_exp[i]));
      complete(d, e);
      check($sformatf("rr_done%0d", i), 32'(d), 32'(rr_exp[i]));
    end
    i_req = 2'b00;
    check("rr_rdata_kept", 32'(o_req_rdata), 32'h1234);

    // 4: bad op from requester 0 (ptr back at 0)
    i_req_op = 4'b0011;
    i_req    = 2'b01;
    tick();
    tick();
    check("bad_ack", 32'(o_req_ack), 32'h1);
    check("bad_begin", 32'(o_operation_begin), 32'h0);
    i_req = 2'b00;
    tick();
    check("bad_done", 32'(o_req_done), 32'h1);
    check("bad_err", 32'(o_req_err), 32'h1);
    check("bad_begin2", 32'(o_operation_begin), 32'h0);
    tick();

    // 5: busy gate, then reset during WAIT
    i_mdio_master_busy = 1'b1;
    i_req_op = 4'b0101;
    i_req    = 2'b10;
    repeat (4) tick();
    check("busy_no_ack", 32'(o_req_ack), 32'h0);
    i_mdio_master_busy = 1'b0;
    tick();
    tick();
    check("busy_ack", 32'(o_req_ack), 32'h2);
    i_req = 2'b00;
    tick();
    sys_rst_n = 1'b0;
    tick();
    check("rstw_outs", {o_req_ack, o_req_done, o_req_err, o_operation_begin, o_operation},
          32'h0);
    check("rstw_rdata", 32'(o_req_rdata), 32'h0);
    sys_rst_n = 1'b1;
    i_req = 2'b11;
    tick();
    tick();
    check("rstw_ptr0_ack", 32'(o_req_ack), 32'h1);
    i_req = 2'b00;
    complete(d, e);
    check("rstw_done", 32'(d), 32'h1);

`ifdef MDIO_TIMEOUT_EN
    // 6: timeout; finish never asserted
    i_req_op = 4'b0010;
    i_req    = 2'b01;
    tick();
    tick();
    check("to_begin", 32'(o_operation_begin), 32'h1);
    i_req = 2'b00;
    n = 0;
    got_done = 1'b0;
    while (!got_done && n < 300) begin
      tick();
      n++;
      if (o_req_done != 2'b00) got_done = 1'b1;
    end
    check("to_latency", 32'(n), 32'd101);
    check("to_err", 32'(o_req_err), 32'h1);
    check("to_rdata", 32'(o_req_rdata), 32'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
